// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage feeding alu_top: MIPS field decode, 32x32 register
// file with writeback bypass, and a single valid/ready output slot.
module alu_operand_stage #(
  parameter bit RESET_REGS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  func_field,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [4:0]  dest,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic [31:0] regs [32];
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic [31:0] rs_val, rt_val;
  logic [5:0]  d_func;
  logic [31:0] d_a, d_b;
  logic [4:0]  d_dest;
  logic        d_illegal;
  logic        capture;

  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  // Entry 0 is never written; reads of index 0 are forced to zero below.
  if (RESET_REGS) begin : g_rf_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (wb_en && wb_addr != 5'd0) begin
        regs[wb_addr] <= wb_data;
      end
    end
  end else begin : g_rf_norst
    always_ff @(posedge clk) begin
      if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0) rs_val = (wb_en && wb_addr == rs) ? wb_data : regs[rs];
    if (rt != 5'd0) rt_val = (wb_en && wb_addr == rt) ? wb_data : regs[rt];
  end

  always_comb begin
    d_func    = '0;
    d_a       = '0;
    d_b       = '0;
    d_dest    = '0;
    d_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        d_a    = rs_val;
        d_b    = rt_val;
        d_func = instr[5:0];
        d_dest = rd;
      end
      OP_LW, OP_ADDI: begin
        d_a    = rs_val;
        d_b    = imm_sext;
        d_dest = rt;
      end
      OP_SW: begin
        d_a = rs_val;
        d_b = imm_sext;
      end
      OP_BEQ: begin
        d_a = rs_val;
        d_b = rt_val;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  // Data outputs only change on capture, so a drain leaves them holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      opcode     <= '0;
      func_field <= '0;
      A          <= '0;
      B          <= '0;
      dest       <= '0;
      illegal    <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      opcode     <= op;
      func_field <= d_func;
      A          <= d_a;
      B          <= d_b;
      dest       <= d_dest;
      illegal    <= d_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table streamed through a
// scoreboard queue, plus stall, bypass and async-reset sequences.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic        il;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_ready;
  logic        out_valid;
  logic [5:0]  opcode;
  logic [5:0]  func_field;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  dest;
  logic        illegal;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  vec_t tbl[8];

  alu_operand_stage #(.RESET_REGS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .out_ready(out_ready),
    .out_valid(out_valid), .opcode(opcode), .func_field(func_field), .A(A), .B(B),
    .dest(dest), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1;
    wb_addr = a;
    wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  // A transfer sampled here completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("opcode", {26'd0, opcode}, {26'd0, e.op});
        chk("func_field", {26'd0, func_field}, {26'd0, e.fn});
        chk("A", A, e.a);
        chk("B", B, e.b);
        chk("dest", {27'd0, dest}, {27'd0, e.d});
        chk("illegal", {31'd0, illegal}, {31'd0, e.il});
      end
    end
  end

  initial begin
    rst_n = 1'b0; instr = '0; in_valid = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;

    tbl[0] = '{32'h00221820, '{6'h00, 6'h20, 32'h00002222, 32'h00001111, 5'd3, 1'b0}};
    tbl[1] = '{32'h8C24FFFC, '{6'h23, 6'h00, 32'h00002222, 32'hFFFFFFFC, 5'd4, 1'b0}};
    tbl[2] = '{32'h20477FFF, '{6'h08, 6'h00, 32'h00001111, 32'h00007FFF, 5'd7, 1'b0}};
    tbl[3] = '{32'hAC228000, '{6'h2B, 6'h00, 32'h00002222, 32'hFFFF8000, 5'd0, 1'b0}};
    tbl[4] = '{32'h00014020, '{6'h00, 6'h20, 32'h00000000, 32'h00002222, 5'd8, 1'b0}};
    tbl[5] = '{32'hFC221820, '{6'h3F, 6'h00, 32'h00000000, 32'h00000000, 5'd0, 1'b1}};
    tbl[6] = '{32'h10220005, '{6'h04, 6'h00, 32'h00002222, 32'h00001111, 5'd0, 1'b0}};
    tbl[7] = '{32'h00C64822, '{6'h00, 6'h22, 32'h80000001, 32'h80000001, 5'd9, 1'b0}};

    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_opcode", {26'd0, opcode}, 32'd0);
    chk("rst_func", {26'd0, func_field}, 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_dest", {27'd0, dest}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #9 rst_n = 1'b1;
    step();

    wb_write(5'd1, 32'h00002222);
    wb_write(5'd2, 32'h00001111);
    wb_write(5'd6, 32'h80000001);
    wb_write(5'd10, 32'h0000A0A0);
    wb_write(5'd0, 32'h0000DEAD);

    for (int i = 0; i < 8; i++) begin
      instr = tbl[i].instr;
      in_valid = 1'b1;
      sb.push_back(tbl[i].e);
      step();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step(); step();
    chk("table_drained", sb.size(), 32'd0);

    // Writeback to a source register in the capture cycle must be bypassed.
    instr = 32'h10A50000; in_valid = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h00005555;
    sb.push_back('{6'h04, 6'h00, 32'h00005555, 32'h00005555, 5'd0, 1'b0});
    step();
    in_valid = 1'b0; wb_en = 1'b0;
    step(); step();
    chk("bypass_drained", sb.size(), 32'd0);

    // Stall: first instruction held, later writeback must not alter the snapshot.
    out_ready = 1'b0;
    instr = 32'h01425820; in_valid = 1'b1;
    sb.push_back('{6'h00, 6'h20, 32'h0000A0A0, 32'h00001111, 5'd11, 1'b0});
    step();
    instr = 32'h214C0004;
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'h0000BBBB;
    step();
    wb_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_A", A, 32'h0000A0A0);
      chk("stall_dest", {27'd0, dest}, 32'd11);
      step();
    end
    out_ready = 1'b1;
    sb.push_back('{6'h08, 6'h00, 32'h0000BBBB, 32'h00000004, 5'd12, 1'b0});
    step();
    in_valid = 1'b0;
    chk("second_valid", {31'd0, out_valid}, 32'd1);
    chk("second_A", A, 32'h0000BBBB);
    chk("second_dest", {27'd0, dest}, 32'd12);
    step(); step();
    chk("stall_drained", sb.size(), 32'd0);

    for (int i = 0; i < 4; i++) begin
      instr = tbl[i].instr;
      in_valid = 1'b1;
      sb.push_back(tbl[i].e);
      step();
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step(); step();
    chk("b2b_drained", sb.size(), 32'd0);

    // Async reset while stalled discards the held instruction.
    out_ready = 1'b0;
    instr = tbl[0].instr; in_valid = 1'b1;
    sb.push_back(tbl[0].e);
    step();
    in_valid = 1'b0;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #4 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_A", A, 32'd0);
    chk("async_rst_dest", {27'd0, dest}, 32'd0);
    sb.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    instr = 32'h00221820; in_valid = 1'b1;
    sb.push_back('{6'h00, 6'h20, 32'h00000000, 32'h00000000, 5'd3, 1'b0});
    step();
    in_valid = 1'b0;
    chk("post_reset_A", A, 32'd0);
    step(); step();
    chk("final_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
